// File: rtl/cordic_rotation_engine.sv
// cordic_rotation_engine
// Iterative rotation-mode CORDIC. Rotates (x_in, y_in) by the binary angle angle_in
// (2^32 = 360 degrees). The angle is first folded into [-90, +90) degrees by a +/-90
// degree pre-rotation of the vector, then ITERS micro-rotations drive the residual to 0.
//
// Optional feature macro: CORDIC_GAIN_COMP_EN
//   defined   : adds a GAIN state that scales x/y by K = 0.6072529350 (rounded),
//               latency ITERS+2 edges from the accepting edge to done.
//   undefined : outputs carry the CORDIC gain (~1.6468), latency ITERS+1 edges.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request pulse, sampled only while idle
//   x_in      in   [31:0] signed x operand
//   y_in      in   [31:0] signed y operand
//   angle_in  in   [31:0] binary angle
//   busy      out  high from the accepting edge until done
//   done      out  one-cycle pulse, x_out/y_out valid
//   x_out     out  [31:0] signed rotated x (saturated), held until next result
//   y_out     out  [31:0] signed rotated y (saturated), held until next result
module cordic_rotation_engine #(
  parameter int unsigned ITERS = 24,
  parameter int unsigned GUARD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] angle_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] x_out,
  output logic [31:0] y_out
);

  localparam int unsigned W = 32 + GUARD;
  localparam logic [4:0]  LastIter = 5'(ITERS - 1);

  typedef enum logic [1:0] {StIdle, StRot, StGain, StOut} state_e;

  state_e              r_state, w_state_d;
  logic signed [W-1:0] r_x, r_y, w_x_d, w_y_d;
  logic signed [31:0]  r_z, w_z_d;
  logic [4:0]          r_iter, w_iter_d;
  logic                r_busy, w_busy_d;
  logic                r_done, w_done_d;
  logic [31:0]         r_x_out, r_y_out, w_x_out_d, w_y_out_d;

  // Clamp a W-bit signed value into the 32-bit signed range.
  function automatic logic [31:0] sat32(input logic signed [W-1:0] v);
    if ((&v[W-1:31]) || ~(|v[W-1:31])) return v[31:0];
    return v[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  // atan(2^-i) in the same binary-angle unit.
  logic signed [31:0] w_atan;
  always_comb begin
    w_atan = '0;
    unique case (r_iter)
      5'd0:  w_atan = 32'h2000_0000;
      5'd1:  w_atan = 32'h12E4_051D;
      5'd2:  w_atan = 32'h09FB_385B;
      5'd3:  w_atan = 32'h0511_11D4;
      5'd4:  w_atan = 32'h028B_0D43;
      5'd5:  w_atan = 32'h0145_D7E1;
      5'd6:  w_atan = 32'h00A2_F61E;
      5'd7:  w_atan = 32'h0051_7C55;
      5'd8:  w_atan = 32'h0028_BE53;
      5'd9:  w_atan = 32'h0014_5F2F;
      5'd10: w_atan = 32'h000A_2F98;
      5'd11: w_atan = 32'h0005_17CC;
      5'd12: w_atan = 32'h0002_8BE6;
      5'd13: w_atan = 32'h0001_45F3;
      5'd14: w_atan = 32'h0000_A2FA;
      5'd15: w_atan = 32'h0000_517D;
      5'd16: w_atan = 32'h0000_28BE;
      5'd17: w_atan = 32'h0000_145F;
      5'd18: w_atan = 32'h0000_0A30;
      5'd19: w_atan = 32'h0000_0518;
      5'd20: w_atan = 32'h0000_028C;
      5'd21: w_atan = 32'h0000_0146;
      5'd22: w_atan = 32'h0000_00A3;
      5'd23: w_atan = 32'h0000_0051;
      5'd24: w_atan = 32'h0000_0029;
      5'd25: w_atan = 32'h0000_0014;
      5'd26: w_atan = 32'h0000_000A;
      5'd27: w_atan = 32'h0000_0005;
      5'd28: w_atan = 32'h0000_0003;
      5'd29: w_atan = 32'h0000_0001;
      5'd30: w_atan = 32'h0000_0001;
      default: w_atan = '0;
    endcase
  end

  // Pre-rotation. Operands are widened first so negating 0x80000000 cannot overflow.
  logic signed [W-1:0] w_xin_ext, w_yin_ext, w_pre_x, w_pre_y;
  logic signed [31:0]  w_pre_z;
  assign w_xin_ext = {{GUARD{x_in[31]}}, x_in};
  assign w_yin_ext = {{GUARD{y_in[31]}}, y_in};

  always_comb begin
    w_pre_x = w_xin_ext;
    w_pre_y = w_yin_ext;
    w_pre_z = angle_in;
    unique case (angle_in[31:30])
      2'b01: begin
        w_pre_x = -w_yin_ext;
        w_pre_y = w_xin_ext;
        w_pre_z = angle_in - 32'h4000_0000;
      end
      2'b10: begin
        w_pre_x = w_yin_ext;
        w_pre_y = -w_xin_ext;
        w_pre_z = angle_in + 32'h4000_0000;
      end
      default: ;
    endcase
  end

  // One micro-rotation; direction follows the sign of the residual angle.
  logic signed [W-1:0] w_xs, w_ys, w_rot_x, w_rot_y;
  logic signed [31:0]  w_rot_z;
  logic                w_dpos;
  assign w_xs    = r_x >>> r_iter;
  assign w_ys    = r_y >>> r_iter;
  assign w_dpos  = ~r_z[31];
  assign w_rot_x = w_dpos ? (r_x - w_ys) : (r_x + w_ys);
  assign w_rot_y = w_dpos ? (r_y + w_xs) : (r_y - w_xs);
  assign w_rot_z = w_dpos ? (r_z - w_atan) : (r_z + w_atan);

`ifdef CORDIC_GAIN_COMP_EN
  // x*K with K in Q0.32, rounded half-up; |x*K| is far below the W-bit range.
  localparam int unsigned PW = W + 33;
  localparam logic [32:0] KGain = 33'h0_9B74_EDA8;
  logic signed [PW-1:0] w_gx_p, w_gy_p, w_gx_r, w_gy_r;
  logic signed [W-1:0]  w_gain_x, w_gain_y;
  assign w_gx_p   = $signed(PW'(r_x)) * $signed(PW'(KGain));
  assign w_gy_p   = $signed(PW'(r_y)) * $signed(PW'(KGain));
  assign w_gx_r   = w_gx_p + $signed(PW'(33'h0_8000_0000));
  assign w_gy_r   = w_gy_p + $signed(PW'(33'h0_8000_0000));
  assign w_gain_x = w_gx_r[W+31:32];
  assign w_gain_y = w_gy_r[W+31:32];
`endif

  always_comb begin
    w_state_d = r_state;
    w_x_d     = r_x;
    w_y_d     = r_y;
    w_z_d     = r_z;
    w_iter_d  = r_iter;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_x_out_d = r_x_out;
    w_y_out_d = r_y_out;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_x_d     = w_pre_x;
          w_y_d     = w_pre_y;
          w_z_d     = w_pre_z;
          w_iter_d  = '0;
          w_busy_d  = 1'b1;
          w_state_d = StRot;
        end
      end
      StRot: begin
        w_x_d = w_rot_x;
        w_y_d = w_rot_y;
        w_z_d = w_rot_z;
        if (r_iter == LastIter) begin
`ifdef CORDIC_GAIN_COMP_EN
          w_state_d = StGain;
`else
          w_state_d = StOut;
`endif
        end else begin
          w_iter_d = r_iter + 5'd1;
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      StGain: begin
        w_x_d     = w_gain_x;
        w_y_d     = w_gain_y;
        w_state_d = StOut;
      end
`endif
      StOut: begin
        w_x_out_d = sat32(r_x);
        w_y_out_d = sat32(r_y);
        w_done_d  = 1'b1;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_x_out <= '0;
      r_y_out <= '0;
    end else begin
      r_state <= w_state_d;
      r_x     <= w_x_d;
      r_y     <= w_y_d;
      r_z     <= w_z_d;
      r_iter  <= w_iter_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_x_out <= w_x_out_d;
      r_y_out <= w_y_out_d;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign x_out = r_x_out;
  assign y_out = r_y_out;

endmodule

// File: doc/cordic_rotation_engine.md
Name: cordic_rotation_engine

Overview:
- Iterative rotation-mode CORDIC: rotates (x_in, y_in) by angle_in and returns the rotated vector.
- It is the inverse-direction partner of the vectoring-mode quadrant pre-correction path.
  - Vectoring folds a vector into the right half-plane and accumulates the angle.
  - This block folds the target angle into [-90°, +90°], pre-rotates the vector by ±90°, and iterates the residual angle to zero.
- Sits in the VECTOR datapath as the polar-to-rectangular and rotate stage, driven by a start/done handshake.

Parameters:
- ITERS, 24, number of micro-rotations; legal range 8..30.
- GUARD, 2, extra MSBs on internal x/y to absorb CORDIC gain growth.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- x_in  in  32  signed x operand.
- y_in  in  32  signed y operand.
- angle_in  in  32  binary angle; full 32-bit wrap = 360°, 0x40000000 = +90°, 0x80000000 = -180°.
- busy  out  1  high from the accepting edge until done is asserted.
- done  out  1  one-cycle pulse; x_out/y_out are valid on this cycle.
- x_out  out  32  signed rotated x, held until the next result.
- y_out  out  32  signed rotated y, held until the next result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, x_out=0, y_out=0; iteration counter=0. Reset mid-operation aborts the computation and produces no done.
- States: IDLE -> ROT -> (GAIN, only if the optional feature is enabled) -> OUT -> IDLE.
- IDLE: on an edge with start=1, capture operands, apply pre-rotation, set busy=1, counter i=0, and go to ROT.
- Pre-rotation, keyed on angle_in[31:30]:
  - 00 or 11: no change; z = angle_in.
  - 01 (+90°..+180°): x = -y_in, y = x_in, z = angle_in - 0x40000000.
  - 10 (-180°..-90°): x = y_in, y = -x_in, z = angle_in + 0x40000000.
- Pre-rotation arithmetic: operands are sign-extended to 32+GUARD bits before negation, so -0x80000000 does not overflow.
- ROT, one micro-rotation per edge:
  - d = +1 if z >= 0, else -1.
  - x' = x - d·(y>>>i); y' = y + d·(x>>>i); z' = z - d·atan_tab[i].
  - Shifts are arithmetic.
  - After the edge with i = ITERS-1, go to GAIN or OUT.
- atan_tab (32-bit, same angle unit), i=0..7: 0x20000000, 0x12E4051D, 0x09FB385B, 0x051111D4, 0x028B0D43, 0x0145D7E1, 0x00A2F61E, 0x00517C55. Remaining entries are round(atan(2^-i)·2^32/2π), up to i=30.
- OUT: write saturated x/y to x_out/y_out, pulse done=1 for one cycle, clear busy, return to IDLE.
  - Saturation: values above 0x7FFFFFFF clamp to 0x7FFFFFFF; values below 0x80000000 clamp to 0x80000000.
- Latency from the accepting edge to done high:
  - ITERS+1 edges without the optional feature.
  - ITERS+2 edges with it.
  - Back-to-back: start may be asserted on the done cycle, because the state is already IDLE at the next edge.
- start while busy=1 is ignored; no queuing.
- Accuracy: residual angle error ≤ atan(2^-(ITERS-1)); result error ≤ 4 LSB·2^(32-ITERS) relative to full scale.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined:
  - Adds the GAIN state, which multiplies x and y by K = 0.6072529350 (Q0.32 constant 0x9B74EDA8), rounds to nearest, then saturates.
  - Output magnitude ≈ input magnitude.
  - Adds one cycle of latency.
- Undefined:
  - No GAIN state; outputs carry CORDIC gain ≈1.646760258.
  - Saturation applies if |input|·1.6468 exceeds the 32-bit range.

Test Plan:
- Gain comp on; x_in=0x10000000, y_in=0, angle=0x00000000 -> x_out≈0x10000000, y_out≈0 (±16 LSB); done exactly ITERS+2 edges after start.
- Gain comp on; x_in=0x10000000, y_in=0, angle=0x40000000 (+90°) -> x_out≈0, y_out≈0x10000000. Repeat with 0x60000000 (+135°) -> x_out≈-0x0B504F33, y_out≈+0x0B504F33.
- Gain comp on; x_in=0x10000000, y_in=0, angle=0x80000000 (-180°) -> x_out≈-0x10000000, y_out≈0. Angle 0xC0000000 (-90°) -> y_out≈-0x10000000.
- Gain comp off; x_in=0x7FFFFFFF, y_in=0, angle=0 -> x_out=0x7FFFFFFF (saturated); done ITERS+1 edges after start.
- Assert start again on cycles 3..10 while busy -> ignored, exactly one done. Then start on the done cycle -> second result with correct latency.
- Drop rst_n mid-ROT at iteration 5 -> busy=0, done=0, x_out=y_out=0 immediately. After release, a fresh start completes normally.
